// File: rtl/note_player_pkg.sv
// Shared definitions for the note controller and note player:
// default count width, FSM encodings and note half-period constants.
package note_player_pkg;

    localparam int W_DEF = 28;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Half-period overflow counts for a 50 MHz clock
    localparam int DO4  = 95556;
    localparam int RE4  = 85131;
    localparam int MI4  = 75843;
    localparam int FA4  = 71586;
    localparam int SOL4 = 63776;
    localparam int LA4  = 56818;
    localparam int SI4  = 50619;
    localparam int DO5  = 47778;

endpackage

// File: rtl/note_player_tone_divider.sv
// Half-period counter and toggle flop producing the raw square wave.
// A half period of zero holds the flop low (rest).
module tone_divider
    import note_player_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         run,
    input  logic         clr,
    input  logic [W-1:0] half_period,
    output logic         tone
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] r_half_cnt;
    logic         r_tone;
    logic         w_last;

    assign w_last = (r_half_cnt == half_period - ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_half_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (clr) begin
            r_half_cnt <= '0;
            r_tone     <= 1'b0;
        end else if (run && (half_period != '0)) begin
            if (w_last) begin
                r_half_cnt <= '0;
                r_tone     <= ~r_tone;
            end else begin
                r_half_cnt <= r_half_cnt + ONE;
            end
        end
    end

    assign tone = r_tone;

endmodule

// File: rtl/note_player.sv
// Plays one latched note as a gated square wave, reports busy (duracao)
// and pulses note_done when returning to IDLE.
module note_player
    import note_player_pkg::*;
#(
    parameter int W          = W_DEF,
    parameter int GAP_CYCLES = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         pause,
    input  logic         disparo,
    input  logic [W-1:0] freq_ov,
    input  logic [W-1:0] temp_ov,
    output logic         audio_out,
    output logic         duracao,
    output logic         note_done
);

    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] GAP_LAST =
        W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic         HAS_GAP  = (GAP_CYCLES > 0);

    state_t       r_state;
    state_t       w_next;
    logic [W-1:0] r_freq;
    logic [W-1:0] r_temp;
    logic [W-1:0] r_dur_cnt;
    logic [W-1:0] r_gap_cnt;
    logic         r_done;

    logic         w_run;
    logic         w_load;
    logic         w_to_idle;
    logic         w_dur_last;
    logic         w_gap_last;
    logic [W-1:0] w_temp_eff;
    logic         w_tone;

    assign w_run      = ena & ~pause;
    assign w_load     = w_run & disparo & (r_state == ST_IDLE);
    assign w_temp_eff = (temp_ov == '0) ? ONE : temp_ov;
    assign w_dur_last = (r_dur_cnt == r_temp - ONE);
    assign w_gap_last = (r_gap_cnt == GAP_LAST);

    always_comb begin
        w_next    = r_state;
        w_to_idle = 1'b0;
        if (w_run) begin
            unique case (r_state)
                ST_IDLE: begin
                    if (disparo)
                        w_next = ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_dur_last) begin
                        if (HAS_GAP) begin
                            w_next = ST_GAP;
                        end else begin
                            w_next    = ST_IDLE;
                            w_to_idle = 1'b1;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_last) begin
                        w_next    = ST_IDLE;
                        w_to_idle = 1'b1;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_to_idle;
        end
    end

    // Limits are captured only at load; later input changes are ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_freq    <= '0;
            r_temp    <= '0;
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
        end else if (w_load) begin
            r_freq    <= freq_ov;
            r_temp    <= w_temp_eff;
            r_dur_cnt <= '0;
            r_gap_cnt <= '0;
        end else if (w_run) begin
            if ((r_state == ST_PLAY) && !w_dur_last)
                r_dur_cnt <= r_dur_cnt + ONE;
            if ((r_state == ST_GAP) && !w_gap_last)
                r_gap_cnt <= r_gap_cnt + ONE;
        end
    end

    tone_divider #(
        .W(W)
    ) u_tone (
        .clk        (clk),
        .rst        (rst),
        .run        (w_run & (r_state == ST_PLAY)),
        .clr        (w_load),
        .half_period(r_freq),
        .tone       (w_tone)
    );

    assign audio_out = w_run & (r_state == ST_PLAY)
                     & (r_freq != '0) & w_tone;
    assign duracao   = (r_state != ST_IDLE);
    assign note_done = r_done;

endmodule
